alu_pipe: RTL

Parametrised, handshaked successor to the datapath ALU. It accepts one operation per valid/ready transfer, registers result and flags, and adds a multi-cycle shift-add multiplier, shifts and signed-free set-less-than. It sits between the decode/register-read stage and writeback/memory-address logic, and applies backpressure while busy.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 60 ++++++
 rtl/alu_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the pipelined, handshaked ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XOR    = 4'b0100;
    localparam logic [3:0] OP_CMP    = 4'b0101;
    localparam logic [3:0] OP_LDADDR = 4'b0110;
    localparam logic [3:0] OP_STADDR = 4'b0111;
    localparam logic [3:0] OP_MUL    = 4'b1000;
    localparam logic [3:0] OP_SHL    = 4'b1001;
    localparam logic [3:0] OP_SHR    = 4'b1010;
    localparam logic [3:0] OP_SLT    = 4'b1011;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// done is combinational and coincides with the edge that retires the last bit.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic                 active_reg;
    logic [CW-1:0]        count_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;

    // Partial product: shifted multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_next = acc_reg + addend;
    assign done     = active_reg && (count_reg == CW'(WIDTH-1));
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            count_reg  <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
        end else if (active_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            count_reg  <= count_reg + CW'(1);
            if (count_reg == CW'(WIDTH-1)) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops register on the transfer edge, MUL runs
// through the sequential multiplier and holds off new work until it retires.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [3:0]       opcode,
    input  logic             ALU_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             compare,
    output logic             zero,
    output logic             carry,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               compare_reg;
    logic               zero_reg;
    logic               carry_reg;
    logic               illegal_reg;

    logic               xfer;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   result_next;
    logic               compare_next;
    logic               carry_next;
    logic               illegal_next;

    assign in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign xfer     = in_valid && in_ready;
    assign is_mul   = ALU_src && (opcode == OP_MUL) && MUL_EN;

    assign sum_w  = {1'b0, data_in1} + {1'b0, data_in2};
    assign diff_w = {1'b0, data_in1} - {1'b0, data_in2};
    assign shamt  = data_in2[SHW-1:0];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (xfer && is_mul),
        .a       (data_in1),
        .b       (data_in2),
        .done    (mul_done),
        .product (mul_product)
    );

    // The borrow bit of the subtraction doubles as the unsigned less-than for SLT.
    always_comb begin
        result_next  = '0;
        compare_next = 1'b0;
        carry_next   = 1'b0;
        illegal_next = 1'b0;
        if (!ALU_src) begin
            result_next = data_in2;
        end else begin
            case (opcode)
                OP_ADD, OP_LDADDR, OP_STADDR: begin
                    result_next = sum_w[WIDTH-1:0];
                    carry_next  = sum_w[WIDTH];
                end
                OP_SUB: begin
                    result_next = diff_w[WIDTH-1:0];
                    carry_next  = diff_w[WIDTH];
                end
                OP_AND: result_next = data_in1 & data_in2;
                OP_OR:  result_next = data_in1 | data_in2;
                OP_XOR: result_next = data_in1 ^ data_in2;
                OP_CMP: compare_next = (data_in1 == data_in2);
                OP_MUL: illegal_next = !MUL_EN;
                OP_SHL: result_next = data_in1 << shamt;
                OP_SHR: result_next = data_in1 >> shamt;
                OP_SLT: result_next = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
                default: illegal_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            compare_reg   <= 1'b0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (xfer) begin
            if (is_mul) begin
                state_reg     <= ST_MUL_BUSY;
                out_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= 1'b1;
                result_reg    <= result_next;
                compare_reg   <= compare_next;
                zero_reg      <= (result_next == '0);
                carry_reg     <= carry_next;
                illegal_reg   <= illegal_next;
            end
        end else if ((state_reg == ST_MUL_BUSY) && mul_done) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b1;
            result_reg    <= mul_product[WIDTH-1:0];
            compare_reg   <= 1'b0;
            zero_reg      <= (mul_product[WIDTH-1:0] == '0);
            carry_reg     <= |mul_product[2*WIDTH-1:WIDTH];
            illegal_reg   <= 1'b0;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign compare   = compare_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign illegal   = illegal_reg;
    assign busy      = (state_reg == ST_MUL_BUSY);

endmodule
